multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32 subset datapath: R-type, lw, sw, beq/bne/blt/bge, jal.
- Replaces single-cycle decode when instruction and data share one memory port with a ready handshake.
- Drives PC/IR enables, memory request, ALU operand selects, immsel/aluop, and register write-back state by state.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- func3  in  3  IR[14:12]
- zero  in  1  ALU result zero
- lt  in  1  ALU signed less-than
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch IR and OldPC
- pc_write  out  1  PC enable
- reg_write  out  1  register file write
- immsel  out  2  immediate select: 00 I, 01 S, 10 B, 11 J
- aluop  out  2  ALU op: 00 add, 01 sub/compare, 10 funct-decoded
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 reg
- alu_src_b  out  2  ALU B select: 00 rs2 reg, 01 imm, 10 const 4
- result_src  out  2  result select: 00 ALUOut, 01 mem data reg, 10 ALU direct
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- retire  out  1  one-cycle pulse when an instruction completes
- retire_cnt  out  CNT_W  retired-instruction count
- state  out  4  current state, for debug

Behaviour:
- Reset: rst is sampled on the clk rising edge. Reset forces state FETCH, retire_cnt=0, and drops all pending requests.
- During any cycle with rst high, every output is 0.
- Reset mid-request abandons the transaction; the memory must tolerate a mem_req drop.
- Outputs are Moore (decoded from state), except where a qualifier is listed. Any signal not listed for a state is 0.
- FETCH (0): mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10.
  - On mem_ready: ir_write=1 and pc_write=1 (PC<=PC+4), then go to DECODE. Otherwise stay in FETCH.
- DECODE (1): computes the branch/jump target into ALUOut. alu_src_a=01, alu_src_b=01, aluop=00, immsel=11 if opcode=1101111, else 10. Next state:
  - 0000011 or 0100011: MEMADR
  - 0110011: EXECR
  - 1100011: BRANCH
  - 1101111: JAL
  - any other opcode: FETCH, with illegal_op=1 for this cycle; no retire.
- MEMADR (2): alu_src_a=10, alu_src_b=01, aluop=00, immsel=00 for lw, 01 for sw. Next state MEMRD for lw, MEMWR for sw.
- MEMRD (3): mem_req=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB (4): reg_write=1, result_src=01, retire=1. Next state FETCH.
- MEMWR (5): mem_req=1, mem_we=1, adr_src=1.
  - On mem_ready: retire=1, next state FETCH.
  - mem_we stays high for every cycle mem_req is high in MEMWR.
- EXECR (6): alu_src_a=10, alu_src_b=00, aluop=10. Next state ALUWB.
- ALUWB (7): reg_write=1, result_src=00, retire=1. Next state FETCH.
- BRANCH (8): alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, retire=1. Next state FETCH.
  - pc_write=taken, with taken determined by func3:
    - 000 (beq): zero
    - 001 (bne): !zero
    - 100 (blt): lt
    - 101 (bge): !lt
    - other func3 values: 0
- JAL (9): pc_write=1, result_src=00 (PC<=target). Same cycle: alu_src_a=01, alu_src_b=10, aluop=00, so ALUOut<=OldPC+4. Next state ALUWB, which writes the link register and retires.
- Unused state encodings (10..15) go to FETCH with no outputs asserted.
- retire_cnt increments by 1 on every retire pulse. It wraps from all-ones to 0 with no flag.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- mem_ready in the same cycle mem_req first rises is legal (zero-wait memory).
- Latency with zero-wait memory, in cycles:
  - R-type: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4
- Each wait cycle on mem_ready adds one cycle per memory access.

Test Plan:
- Reset, then add (0110011) with mem_ready tied 1 → state sequence 0,1,6,7,0. reg_write high only in state 7. retire_cnt=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in both FETCH and MEMRD → mem_req held 4 cycles each. ir_write pulses once. reg_write with result_src=01 in state 4. Total 11 cycles.
- sw → in state 5: mem_we=1, adr_src=1, immsel=01 seen in state 2. reg_write never asserted.
- beq with zero=1, then bne with zero=1 → pc_write=1 in state 8 for beq, 0 for bne. Each retires in 3 cycles. func3=010 → pc_write=0.
- jal → state 9 shows pc_write=1 and immsel=11 in DECODE. ALUWB follows with reg_write=1. retire_cnt increments once.
- Opcode 0010111 → illegal_op pulse in DECODE, return to FETCH, no retire. rst asserted mid-MEMRD wait → outputs 0 next cycle, state=0, retire_cnt=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for an RV32 subset (R-type, lw, sw, beq/bne/blt/bge, jal).
// Instruction and data share one memory port with a ready handshake.
// Control outputs are decoded from the current state. A few are also qualified
// by mem_ready, opcode or the branch condition. A counter tracks retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       immsel,
    output logic [1:0]       aluop,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic             illegal_op,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [3:0]       state
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JAL    = 4'd9
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] retire_cnt_reg;
    logic             taken;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Retired-instruction counter. It wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_reg <= '0;
        end else if (retire) begin
            retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
        end
    end

    // Branch condition selected by func3. Unsupported encodings are never taken.
    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            default: taken = 1'b0;
        endcase
    end

    // Next-state and control decode. All outputs are held low while rst is high.
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        immsel     = 2'b00;
        aluop      = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        illegal_op = 1'b0;
        retire     = 1'b0;
        if (rst) begin
            state_next = S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    // Fetch from PC while the ALU computes PC+4 in parallel.
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Compute the branch/jump target speculatively into ALUOut.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    immsel    = (opcode == OP_JAL) ? 2'b11 : 2'b10;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_RTYPE:          state_next = S_EXECR;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        default: begin
                            illegal_op = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    immsel     = (opcode == OP_STORE) ? 2'b01 : 2'b00;
                    state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        state_next = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_EXECR: begin
                    alu_src_a  = 2'b10;
                    aluop      = 2'b10;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    // Compare rs1/rs2; PC loads the target held in ALUOut when taken.
                    alu_src_a  = 2'b10;
                    aluop      = 2'b01;
                    pc_write   = taken;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_JAL: begin
                    // PC takes the target while ALUOut captures the link value OldPC+4.
                    pc_write   = 1'b1;
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    state_next = S_ALUWB;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

    assign retire_cnt = rst ? '0 : retire_cnt_reg;
    assign state      = rst ? 4'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control. Each cycle's inputs and expected outputs
// are listed explicitly. Hand-written sequences cover retire latency and counter wrap.
module tb_multicycle_control;

    localparam int CW = 8;
    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] ILL = 7'b0010111;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic          zero;
    logic          lt;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic          adr_src;
    logic          ir_write;
    logic          pc_write;
    logic          reg_write;
    logic [1:0]    immsel;
    logic [1:0]    aluop;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    result_src;
    logic          illegal_op;
    logic          retire;
    logic [CW-1:0] retire_cnt;
    logic [3:0]    state;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .immsel(immsel),
        .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .illegal_op(illegal_op), .retire(retire),
        .retire_cnt(retire_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        lt;
        logic        rdy;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    // exp layout: state, req, we, adr, irw, pcw, rw, imm, aop, srca, srcb, res, ill, ret, cnt
    task automatic add(input int r, input logic [6:0] op, input int f3, input int z,
                       input int l, input int rdy, input int st, input int req,
                       input int we, input int adr, input int irw, input int pcw,
                       input int rw, input int imm, input int aop, input int sa,
                       input int sb, input int res, input int ill, input int ret,
                       input int cnt);
        vec_t v;
        v.rst = 1'(r);
        v.op  = op;
        v.f3  = 3'(f3);
        v.z   = 1'(z);
        v.lt  = 1'(l);
        v.rdy = 1'(rdy);
        v.exp = {4'(st), 1'(req), 1'(we), 1'(adr), 1'(irw), 1'(pcw), 1'(rw),
                 2'(imm), 2'(aop), 2'(sa), 2'(sb), 2'(res), 1'(ill), 1'(ret), 8'(cnt)};
        tbl.push_back(v);
    endtask

    // One complete branch: FETCH, DECODE, BRANCH with the given expected pc_write.
    task automatic add_branch(input int f3, input int z, input int l, input int tk,
                              input int cnt);
        add(0, BR, f3, z, l, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, cnt);
        add(0, BR, f3, z, l, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0, cnt);
        add(0, BR, f3, z, l, 1, 8, 0, 0, 0, 0, tk, 0, 0, 1, 2, 0, 0, 0, 1, cnt);
    endtask

    function automatic logic [29:0] outs();
        return {state, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                immsel, aluop, alu_src_a, alu_src_b, result_src, illegal_op, retire,
                retire_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic run_branch();
        repeat (3) begin
            @(negedge clk);
            opcode = BR; func3 = 3'b000; zero = 1'b0; lt = 1'b0; mem_ready = 1'b1;
        end
    endtask

    initial begin
        int   cyc;
        logic seen;

        // Reset cycle
        add(1, R, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // R-type, zero-wait: 0,1,6,7
        add(0, R, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0);
        add(0, R, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0, 0);
        add(0, R, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
        add(0, R, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        // lw with three wait cycles in FETCH and in MEMRD: 11 cycles total
        for (int i = 0; i < 3; i++)
            add(0, LW, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 1);
        add(0, LW, 2, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 1);
        add(0, LW, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0, 1);
        add(0, LW, 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            add(0, LW, 2, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, LW, 2, 0, 0, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, LW, 2, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        // sw with one wait cycle in MEMWR
        add(0, SW, 2, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 2);
        add(0, SW, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0, 2);
        add(0, SW, 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 2);
        add(0, SW, 2, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(0, SW, 2, 0, 0, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        // Branches: beq/bne/blt/bge/unsupported func3
        add_branch(0, 1, 0, 1, 3);
        add_branch(1, 1, 0, 0, 4);
        add_branch(4, 0, 1, 1, 5);
        add_branch(5, 0, 1, 0, 6);
        add_branch(2, 1, 1, 0, 7);
        add_branch(0, 0, 0, 0, 8);
        add_branch(5, 0, 0, 1, 9);
        // jal: 0,1,9,7
        add(0, JL, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 10);
        add(0, JL, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0, 10);
        add(0, JL, 0, 0, 0, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 10);
        add(0, JL, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 10);
        // Illegal opcode: pulse in DECODE, back to FETCH, no retire
        add(0, ILL, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 11);
        add(0, ILL, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 1, 0, 11);
        add(0, ILL, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 11);
        // lw aborted by reset during a MEMRD wait
        add(0, LW, 2, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 11);
        add(0, LW, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0, 0, 11);
        add(0, LW, 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 11);
        add(0, LW, 2, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11);
        add(0, LW, 2, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11);
        add(1, LW, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, LW, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; opcode = tbl[i].op; func3 = tbl[i].f3;
            zero = tbl[i].z; lt = tbl[i].lt; mem_ready = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d st=%0d", i, tbl[i].exp[29:26]),
                  {2'b0, outs()}, {2'b0, tbl[i].exp});
            $display("vec%0d rst=%0d op=%b rdy=%0d -> state=%0d cnt=%0d",
                     i, rst, opcode, mem_ready, state, retire_cnt);
        end

        // jal latency: retire must appear on the 4th cycle from FETCH (bounded wait)
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            opcode = JL; func3 = 3'b000; mem_ready = 1'b1;
            #1;
            cyc++;
            seen = retire;
        end
        check("jal_latency", 32'(cyc), 32'd4);
        $display("jal retire after %0d cycles", cyc);

        // Counter wrap: cnt is 1 now; 254 branches reach 255, one more wraps to 0
        for (int i = 0; i < 254; i++) run_branch();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("cnt_255", 32'(retire_cnt), 32'd255);
        $display("after 254 branches cnt=%0d", retire_cnt);
        run_branch();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("cnt_wrap", 32'(retire_cnt), 32'd0);
        check("wrap_state", 32'(state), 32'd0);
        $display("after wrap branch cnt=%0d", retire_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
